// File: rtl/register_file_pkg.sv
// Shared sizing defaults and types for the scoreboarded register file.
package register_file_pkg;

    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned PendWidth    = 2;
    localparam int unsigned NumRegs      = 2 ** RegAddrWidth;

    typedef logic [RegAddrWidth-1:0] reg_idx_t;
    typedef logic [DataWidth-1:0]    reg_data_t;
    typedef logic [PendWidth-1:0]    pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/rf_pend_counter.sv
// Per-register in-flight write counter: saturating increment, underflow-safe
// decrement, and a clear that overrides both.
module rf_pend_counter #(
    parameter int unsigned PendWidth = register_file_pkg::PendWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 clr,
    output logic [PendWidth-1:0] cnt,
    output logic                 is_max,
    output logic                 underflow
);

    localparam logic [PendWidth-1:0] CntMax = '1;
    localparam logic [PendWidth-1:0] CntOne = 1;

    logic [PendWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (dec && !inc) begin
            // A retire with nothing outstanding is reported, never wrapped.
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign is_max = (cnt_q == CntMax);

endmodule

// File: rtl/register_file_sb.sv
// Architectural register file with write bypass and a per-register scoreboard
// that stalls issue on read-after-write hazards and pending-counter overflow.
module register_file_sb #(
    parameter int unsigned DataWidth    = register_file_pkg::DataWidth,
    parameter int unsigned RegAddrWidth = register_file_pkg::RegAddrWidth,
    parameter int unsigned PendWidth    = register_file_pkg::PendWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_en,
    input  logic [RegAddrWidth-1:0] writeBack_reg,
    input  logic [DataWidth-1:0]    WriteBackData,
    input  logic [RegAddrWidth-1:0] rs1_addr,
    input  logic [RegAddrWidth-1:0] rs2_addr,
    output logic [DataWidth-1:0]    rs1_data,
    output logic [DataWidth-1:0]    rs2_data,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic [RegAddrWidth-1:0] issue_rd,
    input  logic                    issue_use_rs1,
    input  logic                    issue_use_rs2,
    output logic                    issue_ready,
    input  logic                    flush,
    output logic                    sb_underflow
);

    localparam int unsigned NumRegs = 2 ** RegAddrWidth;
    localparam logic [PendWidth-1:0] CntOne = 1;

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [PendWidth-1:0] cnt    [NumRegs];
    logic [NumRegs-1:0]   cnt_max;
    logic [NumRegs-1:0]   uf_pulse;
    logic                 wb_commit;
    logic                 issue_fire;
    logic                 haz_rs1, haz_rs2, rd_full;
    logic                 uf_q;

    assign wb_commit = wb_en && (writeBack_reg != '0);

    // Storage; x0 is held at zero and never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_commit) begin
            regs_q[writeBack_reg] <= WriteBackData;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_en && (writeBack_reg == rs1_addr)) begin
            rs1_data = WriteBackData;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_en && (writeBack_reg == rs2_addr)) begin
            rs2_data = WriteBackData;
        end
    end

    // Index 0 has no counter: it can never be pending.
    assign cnt[0]      = '0;
    assign cnt_max[0]  = 1'b0;
    assign uf_pulse[0] = 1'b0;

    for (genvar r = 1; r < NumRegs; r++) begin : g_cnt
        logic inc_r, dec_r;

        assign inc_r = issue_fire && (issue_rd == RegAddrWidth'(r));
        assign dec_r = wb_en && (writeBack_reg == RegAddrWidth'(r));

        rf_pend_counter #(
            .PendWidth (PendWidth)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_r),
            .dec       (dec_r),
            .clr       (flush),
            .cnt       (cnt[r]),
            .is_max    (cnt_max[r]),
            .underflow (uf_pulse[r])
        );
    end

    // A single outstanding write retiring this cycle is covered by the bypass.
    always_comb begin
        haz_rs1 = issue_use_rs1 && (rs1_addr != '0) && (cnt[rs1_addr] != '0);
        if ((cnt[rs1_addr] == CntOne) && wb_en && (writeBack_reg == rs1_addr)) begin
            haz_rs1 = 1'b0;
        end
        haz_rs2 = issue_use_rs2 && (rs2_addr != '0) && (cnt[rs2_addr] != '0);
        if ((cnt[rs2_addr] == CntOne) && wb_en && (writeBack_reg == rs2_addr)) begin
            haz_rs2 = 1'b0;
        end
        rd_full = issue_wr && (issue_rd != '0) && cnt_max[issue_rd];
    end

    assign issue_ready = !(haz_rs1 || haz_rs2 || rd_full);
    assign issue_fire  = issue_valid && issue_ready && issue_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_q <= 1'b0;
        end else if (|uf_pulse) begin
            uf_q <= 1'b1;
        end
    end

    assign sb_underflow = uf_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench: directed cycle table, a flush/underflow sequence and
// randomized traffic, all compared against a behavioural scoreboard model.
module tb_register_file_sb;
    import register_file_pkg::*;

    typedef struct {
        bit        rn;
        bit        wb;
        reg_idx_t  wr;
        reg_data_t wd;
        reg_idx_t  a1;
        reg_idx_t  a2;
        bit        iv;
        bit        iw;
        reg_idx_t  ird;
        bit        u1;
        bit        u2;
        bit        fl;
        reg_data_t e1;
        reg_data_t e2;
        bit        erdy;
        bit        euf;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      wb_en;
    reg_idx_t  writeBack_reg;
    reg_data_t WriteBackData;
    reg_idx_t  rs1_addr, rs2_addr;
    reg_data_t rs1_data, rs2_data;
    logic      issue_valid, issue_wr, issue_use_rs1, issue_use_rs2, issue_ready;
    reg_idx_t  issue_rd;
    logic      flush, sb_underflow;

    int total = 0;
    int bad   = 0;

    reg_data_t m_regs [NumRegs];
    int        m_cnt  [NumRegs];
    bit        m_uf;

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_en         (wb_en),
        .writeBack_reg (writeBack_reg),
        .WriteBackData (WriteBackData),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .issue_valid   (issue_valid),
        .issue_wr      (issue_wr),
        .issue_rd      (issue_rd),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_ready   (issue_ready),
        .flush         (flush),
        .sb_underflow  (sb_underflow)
    );

    function automatic vec_t v(bit rn, bit wb, reg_idx_t wr, reg_data_t wd, reg_idx_t a1,
                               reg_idx_t a2, bit iv, bit iw, reg_idx_t ird, bit u1, bit u2,
                               bit fl, reg_data_t e1, reg_data_t e2, bit erdy, bit euf);
        vec_t t;
        t.rn = rn; t.wb = wb; t.wr = wr; t.wd = wd; t.a1 = a1; t.a2 = a2;
        t.iv = iv; t.iw = iw; t.ird = ird; t.u1 = u1; t.u2 = u2; t.fl = fl;
        t.e1 = e1; t.e2 = e2; t.erdy = erdy; t.euf = euf;
        return t;
    endfunction

    // Reference model, computed straight from the architectural rules.
    function automatic reg_data_t m_read(reg_idx_t a);
        if (a == 0) return '0;
        if (wb_en && writeBack_reg == a) return WriteBackData;
        return m_regs[a];
    endfunction

    function automatic bit m_haz(bit use_it, reg_idx_t a);
        if (!use_it || a == 0 || m_cnt[a] == 0) return 1'b0;
        if (m_cnt[a] == 1 && wb_en && writeBack_reg == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        int max_cnt = (1 << PendWidth) - 1;
        bit full = issue_wr && issue_rd != 0 && m_cnt[issue_rd] == max_cnt;
        return !(m_haz(issue_use_rs1, rs1_addr) || m_haz(issue_use_rs2, rs2_addr) || full);
    endfunction

    task automatic model_edge();
        bit acc = issue_valid && m_ready() && issue_wr;
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
            m_uf = 1'b0;
        end else begin
            if (wb_en && writeBack_reg != 0) m_regs[writeBack_reg] = WriteBackData;
            for (int r = 1; r < NumRegs; r++) begin
                bit inc = acc && issue_rd == r;
                bit dec = wb_en && writeBack_reg == r;
                if (flush) m_cnt[r] = 0;
                else if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
                else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_uf = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t t, bit use_tbl, string tag);
        rst_n = t.rn; wb_en = t.wb; writeBack_reg = t.wr; WriteBackData = t.wd;
        rs1_addr = t.a1; rs2_addr = t.a2; issue_valid = t.iv; issue_wr = t.iw;
        issue_rd = t.ird; issue_use_rs1 = t.u1; issue_use_rs2 = t.u2; flush = t.fl;
        #3;
        check({tag, " rs1 model"}, rs1_data, m_read(rs1_addr));
        check({tag, " rs2 model"}, rs2_data, m_read(rs2_addr));
        check({tag, " ready model"}, 32'(issue_ready), 32'(m_ready()));
        check({tag, " uf model"}, 32'(sb_underflow), 32'(m_uf));
        if (use_tbl) begin
            check({tag, " rs1"}, rs1_data, t.e1);
            check({tag, " rs2"}, rs2_data, t.e2);
            check({tag, " ready"}, 32'(issue_ready), 32'(t.erdy));
            check({tag, " uf"}, 32'(sb_underflow), 32'(t.euf));
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        //             rn wb wr  wd            a1 a2 iv iw ird u1 u2 fl  e1            e2       rdy uf
        tbl.push_back(v(1, 0, 0, 0,            5, 0, 0, 0, 0,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0,  0, 0, 0,  32'hDEADBEEF, 0,        1, 0));
        tbl.push_back(v(1, 1, 0, 32'h1234,     5, 0, 0, 0, 0,  0, 0, 0,  32'hDEADBEEF, 0,        1, 1));
        tbl.push_back(v(1, 0, 0, 0,            0, 5, 0, 0, 0,  0, 0, 0,  0, 32'hDEADBEEF,        1, 1));
        tbl.push_back(v(0, 0, 0, 0,            5, 0, 0, 0, 0,  0, 0, 0,  32'hDEADBEEF, 0,        1, 1));
        tbl.push_back(v(1, 0, 0, 0,            5, 0, 0, 0, 0,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 7,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            7, 0, 1, 0, 0,  1, 0, 0,  0,            0,        0, 0));
        tbl.push_back(v(1, 1, 7, 32'h55,       7, 0, 1, 0, 0,  1, 0, 0,  32'h55,       0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            7, 0, 0, 0, 0,  0, 0, 0,  32'h55,       0,        1, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(1, 0, 0, 0,        0, 0, 1, 1, 9,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 9,  0, 0, 0,  0,            0,        0, 0));
        tbl.push_back(v(1, 1, 9, 32'h99,       0, 9, 1, 1, 9,  0, 0, 0,  0,            32'h99,   0, 0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 9,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 3,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 3,  0, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 1, 3, 32'hA,        3, 0, 0, 0, 0,  0, 0, 1,  32'hA,        0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            3, 0, 1, 0, 0,  1, 0, 0,  32'hA,        0,        1, 0));
        tbl.push_back(v(1, 1, 3, 32'hB,        3, 0, 0, 0, 0,  0, 0, 0,  32'hB,        0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            3, 0, 0, 0, 0,  0, 0, 0,  32'hB,        0,        1, 1));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 4,  0, 0, 0,  0,            0,        1, 1));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 1, 1, 4,  0, 0, 0,  0,            0,        1, 1));
        tbl.push_back(v(0, 0, 0, 0,            4, 0, 0, 0, 0,  1, 0, 0,  0,            0,        0, 1));
        tbl.push_back(v(1, 0, 0, 0,            4, 0, 0, 0, 0,  1, 0, 0,  0,            0,        1, 0));
        tbl.push_back(v(1, 1, 4, 32'h77,       4, 0, 0, 0, 0,  0, 0, 0,  32'h77,       0,        1, 0));
        tbl.push_back(v(1, 0, 0, 0,            4, 0, 0, 0, 0,  0, 0, 0,  32'h77,       0,        1, 1));

        rst_n = 1'b0; wb_en = 1'b0; writeBack_reg = '0; WriteBackData = '0;
        rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_wr = 1'b0;
        issue_rd = '0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        model_edge();
        #1;

        foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("row%0d", i));

        // Flush masks an underflow on the same edge; a later stray writeback does not.
        run_vec(v(0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 1), 1'b1, "fl_rst");
        run_vec(v(1, 1, 6, 32'h66, 6, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 1, 0), 1'b1, "fl_wb");
        run_vec(v(1, 0, 0, 0,      6, 0, 0, 0, 0, 0, 0, 0, 32'h66, 0, 1, 0), 1'b1, "fl_chk");
        run_vec(v(1, 1, 6, 32'h67, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 0), 1'b1, "uf_wb");
        run_vec(v(1, 0, 0, 0,      6, 0, 0, 0, 0, 0, 0, 0, 32'h67, 0, 1, 1), 1'b1, "uf_chk");

        for (int n = 0; n < 3000; n++) begin
            rv = v(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3),
                   reg_idx_t'($urandom_range(0, 7)), $urandom(),
                   reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                   reg_idx_t'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3),
                   '0, '0, 1'b0, 1'b0);
            run_vec(rv, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
